// File: rtl/pairing_io_pkg.sv
// Shared encodings and defaults for the pairing-core serial I/O controller.
package pairing_io_pkg;

  localparam int DEF_WIDTH   = 198;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_TIMEOUT = 1 << 20;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RUN   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    W_UPD,
    W_SHIFT,
    W_COMMIT,
    R_SETUP,
    R_UPD,
    R_SHIFT,
    RUN_WAIT,
    RSP
  } state_e;

endpackage

// File: rtl/pairing_io_ctrl_if.sv
// Command/response bus between a host and the pairing I/O controller.
interface pairing_io_ctrl_if import pairing_io_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [WIDTH-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/pairing_io_shreg.sv
// Operand shift register: parallel load, shift right with serial in at the MSB, LSB out.
module pairing_io_shreg #(
  parameter int WIDTH = 198
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             lsb
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {sin, q[WIDTH-1:1]};
  end

  assign lsb = q[0];

endmodule

// File: rtl/pairing_io_ctrl.sv
// Sequences WRITE/READ/RUN commands onto the pairing core's serial register port.
// Optional run watchdog: define PAIRING_IO_CTRL_TIMEOUT_EN.
module pairing_io_ctrl import pairing_io_pkg::*; #(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  pairing_io_ctrl_if.slave  bus,
  output logic              hold,
  output logic              sel,
  output logic              w,
  output logic              update,
  output logic              ready,
  output logic              i,
  output logic [ADDR_W-1:0] addr,
  input  logic              o,
  input  logic              done
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("pairing_io_ctrl: WIDTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid_q, rsp_err_q;
  logic             accept, last_bit;
  logic             sh_shift, sh_sin, sh_lsb;
  logic [WIDTH-1:0] sh_din, sh_q;

`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
`endif

  assign bus.cmd_ready = (state == IDLE) && !rsp_valid_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign last_bit      = (cnt == CNT_W'(WIDTH - 1));

  // Non-WRITE commands load zeros, so after a WRITE has shifted out its WIDTH bits
  // (or a RUN/reserved never shifts) the register already holds the zero response.
  assign sh_din   = (bus.cmd_op == OP_WRITE) ? bus.cmd_data : '0;
  assign sh_shift = (state == W_UPD) || (state == W_SHIFT) || (state == R_SHIFT);
  assign sh_sin   = (state == R_SHIFT) ? o : 1'b0;

  pairing_io_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .din   (sh_din),
    .shift (sh_shift),
    .sin   (sh_sin),
    .q     (sh_q),
    .lsb   (sh_lsb)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_valid_q ? sh_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hold        <= 1'b1;
      sel         <= 1'b0;
      w           <= 1'b0;
      update      <= 1'b0;
      ready       <= 1'b0;
      i           <= 1'b0;
      addr        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (bus.cmd_op)
            OP_WRITE: begin
              state  <= W_UPD;
              addr   <= bus.cmd_addr;
              hold   <= 1'b1;
              sel    <= 1'b1;
              update <= 1'b1;
            end
            OP_READ: begin
              state <= R_SETUP;
              addr  <= bus.cmd_addr;
              sel   <= 1'b1;
            end
            OP_RUN: begin
              state <= RUN_WAIT;
              addr  <= bus.cmd_addr;
              hold  <= 1'b0;
`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
              wd    <= '0;
`endif
            end
            default: begin
              // Reserved opcode: error response, core port untouched.
              state       <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          endcase
        end
        W_UPD: begin
          update <= 1'b0;
          ready  <= 1'b1;
          i      <= sh_lsb;
          cnt    <= '0;
          state  <= W_SHIFT;
        end
        W_SHIFT: begin
          if (last_bit) begin
            ready <= 1'b0;
            i     <= 1'b0;
            w     <= 1'b1;
            cnt   <= '0;
            state <= W_COMMIT;
          end else begin
            i   <= sh_lsb;
            cnt <= cnt + 1'b1;
          end
        end
        W_COMMIT: begin
          w           <= 1'b0;
          sel         <= 1'b0;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        R_SETUP: begin
          update <= 1'b1;
          state  <= R_UPD;
        end
        R_UPD: begin
          update <= 1'b0;
          ready  <= 1'b1;
          cnt    <= '0;
          state  <= R_SHIFT;
        end
        R_SHIFT: begin
          if (last_bit) begin
            ready       <= 1'b0;
            sel         <= 1'b0;
            cnt         <= '0;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN_WAIT: begin
          if (done) begin
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            hold        <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= RSP;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        RSP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_io_ctrl.sv
// Directed bench for pairing_io_ctrl with a small serial-port core model.
module tb_pairing_io_ctrl;
  import pairing_io_pkg::*;

  localparam int W  = 198;
  localparam int AW = 6;
`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
  localparam int RUN_CYC = 20;
`else
  localparam int RUN_CYC = 500;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold, sel, w, update, ready, i, o;
  logic          done = 1'b0;
  logic [AW-1:0] addr;
  logic [W-1:0]  rd_val = '0;
  int            rd_idx = 0;
  int            w_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  pairing_io_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  pairing_io_ctrl #(.WIDTH(W), .ADDR_W(AW), .TIMEOUT_CYCLES(64)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .bus    (bus),
    .hold   (hold),
    .sel    (sel),
    .w      (w),
    .update (update),
    .ready  (ready),
    .i      (i),
    .addr   (addr),
    .o      (o),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Core model: update restarts the serial read, each ready cycle advances one bit.
  assign o = (rd_idx < W) ? rd_val[rd_idx] : 1'b0;
  always @(posedge clk) begin
    if (update)     rd_idx <= 0;
    else if (ready) rd_idx <= rd_idx + 1;
    if (w) w_cnt <= w_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {hold, sel, w, update, ready, i, bus.rsp_valid, bus.rsp_err, bus.cmd_ready}, 9'b100000001);
    chk({tag, "_addr_data"}, {addr, bus.rsp_data}, '0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_handshake", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  task automatic write_cmd(input logic [AW-1:0] a, input logic [W-1:0] d);
    logic [W-1:0] got;
    bit ok;
    issue(OP_WRITE, a, d);
    chk("wr_upd", {update, sel, hold, ready, w}, 5'b11100);
    chk("wr_addr", addr, a);
    ok  = 1'b1;
    got = '0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      got[k] = i;
      ok &= (ready === 1'b1) && (update === 1'b0) && (w === 1'b0) && (sel === 1'b1);
    end
    chk("wr_bits", got, d);
    chk("wr_ready_win", ok, 1);
    @(negedge clk);
    chk("wr_commit", {w, ready, i, bus.rsp_valid}, 4'b1000);
    @(negedge clk);
    chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, w, hold, bus.cmd_ready}, 5'b10010);
    chk("wr_rsp_data", bus.rsp_data, 0);
    finish_rsp();
  endtask

  task automatic read_cmd(input logic [AW-1:0] a, input logic [W-1:0] exp,
                          input logic exp_hold, input int stall);
    bit ok;
    issue(OP_READ, a, '0);
    chk("rd_setup", {sel, update, ready}, 3'b100);
    chk("rd_addr", addr, a);
    @(negedge clk);
    chk("rd_upd", {sel, update, ready}, 3'b110);
    ok = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      ok &= (ready === 1'b1) && (update === 1'b0) && (w === 1'b0) && (bus.rsp_valid === 1'b0);
    end
    chk("rd_ready_win", ok, 1);
    @(negedge clk);
    chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, ready, sel, hold}, {4'b1000, exp_hold});
    chk("rd_data", bus.rsp_data, exp);
    ok = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      ok &= (bus.rsp_valid === 1'b1) && (bus.rsp_data === exp) && (bus.cmd_ready === 1'b0);
    end
    chk("rd_stall_stable", ok, 1);
    finish_rsp();
  endtask

  initial begin
    logic [W-1:0] d1, d2, r1, r2;
    bit ok;
    d1 = {4'h0, 194'h288162298554054820552a05426081a1842886a58916a6249};
    r1 = {4'h0, 194'h146a6aa0960461280a8a69524658810aa9a460a828068296a};
    d2 = (198'd3 << 99) | 198'hA5;
    r2 = ~r1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset_state");
    rst_n = 1'b1;

    write_cmd(6'd3, d1);

    rd_val = r1;
    read_cmd(6'd5, r1, 1'b1, 10);

    issue(OP_RUN, 6'd0, '0);
    chk("run_start", {hold, sel, w, ready}, 4'b0000);
    ok = 1'b1;
    for (int k = 0; k < RUN_CYC; k++) begin
      @(negedge clk);
      ok &= (hold === 1'b0) && (sel === 1'b0) && (bus.rsp_valid === 1'b0);
    end
    chk("run_wait", ok, 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("run_rsp", {bus.rsp_valid, bus.rsp_err, hold}, 3'b100);
    chk("run_rsp_data", bus.rsp_data, 0);
    finish_rsp();

    rd_val = r2;
    read_cmd(6'd9, r2, 1'b0, 1);

    issue(OP_WRITE, 6'd3, d2);
    for (int k = 0; k <= 100; k++) @(negedge clk);
    chk("abort_bit100", {ready, i}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_w", w_cnt, 1);

    write_cmd(6'd3, d2);
    chk("w_pulses", w_cnt, 2);

    issue(OP_RSVD, 6'd7, '0);
    chk("rsvd_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b11);
    chk("rsvd_quiet", {sel, update, ready, w, i, hold}, 6'b000001);
    chk("rsvd_addr", addr, 6'd3);
    finish_rsp();

`ifdef PAIRING_IO_CTRL_TIMEOUT_EN
    issue(OP_RUN, 6'd1, '0);
    chk("to_start", hold, 0);
    ok = 1'b1;
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      ok &= (bus.rsp_valid === 1'b0) && (hold === 1'b0);
    end
    chk("to_wait", ok, 1);
    @(negedge clk);
    chk("to_rsp", {bus.rsp_valid, bus.rsp_err, hold}, 3'b111);
    finish_rsp();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
